// File: rtl/universal_shift_ctrl.sv
// Command sequencer for a 4-bit universal shift register: turns one command into per-cycle mode/serial/load drive.
// Optional ROR/ROL support is enabled by defining UNIVERSAL_SHIFT_CTRL_ROTATE_EN.
module universal_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] a_par,
  output logic             s1,
  output logic             s0,
  output logic             msb_in,
  output logic             lsb_in,
  output logic [WIDTH-1:0] i_par,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [1:0]       state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is a pure function of state, and the requester holds cmd_valid until then.

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic             fill_q;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [1:0]       mode_q, mode_n, mode_out;
  logic             abort_q, abort_n;
  logic             err_n;
  logic             accept;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_LOAD, OP_SHR, OP_SHL, OP_ASR: op_legal = 1'b1;
`ifdef UNIVERSAL_SHIFT_CTRL_ROTATE_EN
      OP_ROR, OP_ROL:                  op_legal = 1'b1;
`endif
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_mode(input logic [2:0] op);
    case (op)
      OP_LOAD:        op_mode = 2'b11;
      OP_SHL, OP_ROL: op_mode = 2'b10;
      default:        op_mode = 2'b01;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    mode_n      = mode_q;
    remaining_n = remaining;
    abort_n     = abort_q;
    err_n       = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (!op_legal(cmd_op)) begin
            err_n = 1'b1;
          end else begin
            accept  = 1'b1;
            abort_n = 1'b0;
            if (cmd_op == OP_LOAD) begin
              mode_n      = 2'b11;
              remaining_n = CNT_W'(1);
              state_n     = RUN;
            end else if (cmd_count == '0) begin
              mode_n      = 2'b00;
              remaining_n = '0;
              state_n     = DONE;
            end else begin
              mode_n      = op_mode(cmd_op);
              remaining_n = cmd_count;
              state_n     = RUN;
            end
          end
        end
      end
      RUN: begin
        if (cmd_abort) begin
          mode_n  = 2'b00;
          abort_n = 1'b1;
          state_n = DONE;
        end else begin
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            mode_n  = 2'b00;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      remaining <= '0;
      abort_q   <= 1'b0;
      err       <= 1'b0;
      op_q      <= OP_LOAD;
      fill_q    <= 1'b0;
      i_par     <= '0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      remaining <= remaining_n;
      abort_q   <= abort_n;
      err       <= err_n;
      if (accept) begin
        op_q   <= cmd_op;
        fill_q <= cmd_fill;
        i_par  <= cmd_data;
      end
    end
  end

  // An abort must suppress the shift at the very edge it is sampled, so it gates the mode combinationally.
  assign mode_out  = (state == RUN && cmd_abort) ? 2'b00 : mode_q;
  assign s1        = mode_out[1];
  assign s0        = mode_out[0];
  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign aborted   = (state == DONE) && abort_q;
  assign state_dbg = state;

  always_comb begin
    msb_in = 1'b0;
    lsb_in = 1'b0;
    if (mode_out != 2'b00) begin
      case (op_q)
        OP_SHR: msb_in = fill_q;
        OP_SHL: lsb_in = fill_q;
        OP_ASR: msb_in = a_par[WIDTH-1];
`ifdef UNIVERSAL_SHIFT_CTRL_ROTATE_EN
        OP_ROR: msb_in = a_par[0];
        OP_ROL: lsb_in = a_par[WIDTH-1];
`endif
        default: ;
      endcase
    end
  end

`ifndef UNIVERSAL_SHIFT_CTRL_ROTATE_EN
  logic a_par_unused;
  assign a_par_unused = ^a_par[WIDTH-2:0];
`endif

endmodule

// File: tb/tb_universal_shift_ctrl.sv
// Directed bench for universal_shift_ctrl with a behavioural 4-bit universal shift register on the feedback path.
module tb_universal_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_count;
  logic       cmd_fill;
  logic [3:0] cmd_data;
  logic       cmd_abort;
  logic [3:0] a_par;
  logic       s1, s0, msb_in, lsb_in;
  logic [3:0] i_par;
  logic       done, aborted, err;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
    .cmd_abort(cmd_abort), .a_par(a_par), .s1(s1), .s0(s0), .msb_in(msb_in),
    .lsb_in(lsb_in), .i_par(i_par), .done(done), .aborted(aborted), .err(err),
    .state_dbg(state_dbg)
  );

  // Controlled register model: 01 shift right, 10 shift left, 11 load, 00 hold.
  initial a_par = 4'b0000;
  always @(posedge clk) begin
    case ({s1, s0})
      2'b01:   a_par <= {msb_in, a_par[3:1]};
      2'b10:   a_par <= {a_par[2:0], lsb_in};
      2'b11:   a_par <= i_par;
      default: a_par <= a_par;
    endcase
  end

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] cnt, input logic fill,
                          input logic [3:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_fill = fill; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] data);
    send_cmd(3'b000, 3'd0, 1'b0, data);
    @(negedge clk);
    checks++;
    if (a_par !== data || done !== 1'b1) begin
      errors++;
      $display("FAIL preload: a_par=%b done=%b required %b 1", a_par, done, data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_count = 3'd0;
    cmd_fill = 1'b0; cmd_data = 4'h0; cmd_abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s1, s0, i_par, done, aborted, err, state_dbg} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: s1s0=%b%b i_par=%b done=%b aborted=%b err=%b state=%0d required all 0",
               s1, s0, i_par, done, aborted, err, state_dbg);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_load();
    send_cmd(3'b000, 3'd5, 1'b0, 4'b1011);
    checks++;
    if ({s1, s0} !== 2'b11 || i_par !== 4'b1011 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_mode: s1s0=%b%b i_par=%b done=%b required 11 1011 0", s1, s0, i_par, done);
    end
    @(negedge clk);
    checks++;
    if (a_par !== 4'b1011 || done !== 1'b1 || aborted !== 1'b0 || {s1, s0} !== 2'b00) begin
      errors++;
      $display("FAIL load_done: a_par=%b done=%b aborted=%b s1s0=%b%b required 1011 1 0 00",
               a_par, done, aborted, s1, s0);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_ready: cmd_ready=%b done=%b required 1 0", cmd_ready, done);
    end
  endtask

  task automatic test_shr();
    send_cmd(3'b001, 3'd2, 1'b1, 4'b0000);
    checks++;
    if ({s1, s0} !== 2'b01 || msb_in !== 1'b1 || lsb_in !== 1'b0) begin
      errors++;
      $display("FAIL shr_mode: s1s0=%b%b msb=%b lsb=%b required 01 1 0", s1, s0, msb_in, lsb_in);
    end
    @(negedge clk);
    checks++;
    if (a_par !== 4'b1101 || {s1, s0} !== 2'b01 || done !== 1'b0) begin
      errors++;
      $display("FAIL shr_step1: a_par=%b s1s0=%b%b done=%b required 1101 01 0", a_par, s1, s0, done);
    end
    @(negedge clk);
    checks++;
    if (a_par !== 4'b1110 || done !== 1'b1 || {s1, s0} !== 2'b00 || msb_in !== 1'b0) begin
      errors++;
      $display("FAIL shr_done: a_par=%b done=%b s1s0=%b%b msb=%b required 1110 1 00 0",
               a_par, done, s1, s0, msb_in);
    end
  endtask

  task automatic test_asr_and_zero();
    logic [3:0] exp_a [3];
    exp_a[0] = 4'b1100; exp_a[1] = 4'b1110; exp_a[2] = 4'b1111;
    do_load(4'b1000);
    send_cmd(3'b011, 3'd3, 1'b0, 4'b0000);
    checks++;
    if ({s1, s0} !== 2'b01 || msb_in !== 1'b1) begin
      errors++;
      $display("FAIL asr_mode: s1s0=%b%b msb=%b required 01 1", s1, s0, msb_in);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_par !== exp_a[i] || done !== (i == 2)) begin
        errors++;
        $display("FAIL asr_step%0d: a_par=%b done=%b required %b %b", i, a_par, done, exp_a[i], (i == 2));
      end
    end
    send_cmd(3'b010, 3'd0, 1'b1, 4'b0000);
    checks++;
    if (done !== 1'b1 || {s1, s0} !== 2'b00 || lsb_in !== 1'b0 || a_par !== 4'b1111) begin
      errors++;
      $display("FAIL shl_zero: done=%b s1s0=%b%b lsb=%b a_par=%b required 1 00 0 1111",
               done, s1, s0, lsb_in, a_par);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || a_par !== 4'b1111) begin
      errors++;
      $display("FAIL shl_zero_ready: cmd_ready=%b a_par=%b required 1 1111", cmd_ready, a_par);
    end
  endtask

  task automatic test_rotate();
    do_load(4'b1011);
    send_cmd(3'b101, 3'd4, 1'b0, 4'b0000);
`ifdef UNIVERSAL_SHIFT_CTRL_ROTATE_EN
    begin
      logic [3:0] exp_a [4];
      exp_a[0] = 4'b0111; exp_a[1] = 4'b1110; exp_a[2] = 4'b1101; exp_a[3] = 4'b1011;
      checks++;
      if ({s1, s0} !== 2'b10 || lsb_in !== 1'b1) begin
        errors++;
        $display("FAIL rol_mode: s1s0=%b%b lsb=%b required 10 1", s1, s0, lsb_in);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (a_par !== exp_a[i] || done !== (i == 3)) begin
          errors++;
          $display("FAIL rol_step%0d: a_par=%b done=%b required %b %b", i, a_par, done, exp_a[i], (i == 3));
        end
      end
    end
`else
    checks++;
    if (err !== 1'b1 || {s1, s0} !== 2'b00 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rol_illegal: err=%b s1s0=%b%b ready=%b done=%b required 1 00 1 0",
               err, s1, s0, cmd_ready, done);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || a_par !== 4'b1011) begin
      errors++;
      $display("FAIL rol_illegal_after: err=%b a_par=%b required 0 1011", err, a_par);
    end
`endif
    send_cmd(3'b110, 3'd2, 1'b1, 4'b0101);
    checks++;
    if (err !== 1'b1 || {s1, s0} !== 2'b00 || state_dbg !== 2'd0 || i_par !== 4'b1011) begin
      errors++;
      $display("FAIL op110_illegal: err=%b s1s0=%b%b state=%0d i_par=%b required 1 00 0 1011",
               err, s1, s0, state_dbg, i_par);
    end
  endtask

  task automatic test_abort();
    do_load(4'b0001);
    send_cmd(3'b010, 3'd7, 1'b0, 4'b0000);
    checks++;
    if ({s1, s0} !== 2'b10) begin
      errors++;
      $display("FAIL abort_mode: s1s0=%b%b required 10", s1, s0);
    end
    @(negedge clk);
    @(negedge clk);
    cmd_abort = 1'b1;
    #1;
    checks++;
    if (a_par !== 4'b0100 || {s1, s0} !== 2'b00 || lsb_in !== 1'b0) begin
      errors++;
      $display("FAIL abort_gate: a_par=%b s1s0=%b%b lsb=%b required 0100 00 0", a_par, s1, s0, lsb_in);
    end
    @(negedge clk);
    cmd_abort = 1'b0;
    checks++;
    if (a_par !== 4'b0100 || done !== 1'b1 || aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: a_par=%b done=%b aborted=%b required 0100 1 1", a_par, done, aborted);
    end
    @(negedge clk);
    checks++;
    if (aborted !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_clear: aborted=%b ready=%b required 0 1", aborted, cmd_ready);
    end
  endtask

  task automatic test_throughput();
    logic [2:0] ops [3];
    logic [2:0] cnts [3];
    int exp_n [3];
    int n;
    ops[0] = 3'b001; cnts[0] = 3'd3; exp_n[0] = 5;
    ops[1] = 3'b000; cnts[1] = 3'd6; exp_n[1] = 3;
    ops[2] = 3'b011; cnts[2] = 3'd0; exp_n[2] = 2;
    do_load(4'b0101);
    for (int k = 0; k < 3; k++) begin
      send_cmd(ops[k], cnts[k], 1'b0, 4'b0110);
      n = 1;
      while (!cmd_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== exp_n[k]) begin
        errors++;
        $display("FAIL throughput%0d: cycles=%0d required %0d", k, n, exp_n[k]);
      end
      if (k == 0) begin
        checks++;
        if (a_par !== 4'b0000) begin
          errors++;
          $display("FAIL throughput_shr: a_par=%b required 0000", a_par);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(4'b0110);
    send_cmd(3'b001, 3'd5, 1'b0, 4'b0000);
    @(negedge clk);
    checks++;
    if (a_par !== 4'b0011 || {s1, s0} !== 2'b01) begin
      errors++;
      $display("FAIL midrun_step: a_par=%b s1s0=%b%b required 0011 01", a_par, s1, s0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({s1, s0} !== 2'b00 || state_dbg !== 2'd0 || i_par !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset: s1s0=%b%b state=%0d i_par=%b required 00 0 0000", s1, s0, state_dbg, i_par);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || a_par !== 4'b0011) begin
        errors++;
        $display("FAIL midrun_nodone%0d: done=%b a_par=%b required 0 0011", i, done, a_par);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_ready: cmd_ready=%b required 1", cmd_ready);
    end
    do_load(4'b1001);
  endtask

  initial begin
    test_reset();
    test_load();
    test_shr();
    test_asr_and_zero();
    test_rotate();
    test_abort();
    test_throughput();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/universal_shift_ctrl.md
# universal_shift_ctrl

Command sequencer for the 4-bit universal shift register. It accepts one command at a time (parallel load, logical shift, arithmetic shift, rotate) with a repeat count. It then drives the register's mode selects (s1/s0), serial inputs and parallel-load data cycle by cycle, and reports completion with a one-cycle done pulse. The block shares clk with the register and reads the register's parallel output back to supply rotate and arithmetic fill bits.

## Interface
- WIDTH, 4, register width; must match the controlled register
- CNT_W, 3, width of the shift-count field; counts range 0..2^CNT_W-1
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command; high only in IDLE
- cmd_op  input  3  000 LOAD, 001 SHR, 010 SHL, 011 ASR, 100 ROR, 101 ROL, 11x illegal
- cmd_count  input  CNT_W  number of shifts; ignored for LOAD
- cmd_fill  input  1  serial fill bit for SHR/SHL
- cmd_data  input  WIDTH  parallel-load value
- cmd_abort  input  1  stop the current multi-cycle shift early
- a_par  input  WIDTH  register parallel output (feedback)
- s1, s0  output  1 each  register mode: 00 hold, 01 shift right (MSB_in enters the MSB), 10 shift left (LSB_in enters the LSB), 11 parallel load
- msb_in, lsb_in  output  1 each  register serial inputs
- i_par  output  WIDTH  register parallel-load data
- done  output  1  one-cycle completion pulse
- aborted  output  1  valid with done; 1 = command was cut short
- err  output  1  one-cycle pulse on an illegal opcode

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - The handshake (cmd_valid & cmd_ready) at an edge latches op, count, fill and data.
  - The same edge loads the registered s1/s0 with the op's mode (LOAD→11, SHR/ASR/ROR→01, SHL/ROL→10).
  - remaining ← count (1 for LOAD); state → RUN.
- Count 0 on a shift op: s1/s0 stay 00, state → DONE directly.
- Illegal op: err pulses in the next cycle, nothing else changes, state stays IDLE.
- RUN:
  - Each edge decrements remaining.
  - The edge where remaining==1 sets s1/s0 ← 00 and state → DONE.
- DONE:
  - done=1 for exactly one cycle; aborted reflects the abort flag.
  - Next edge → IDLE.
- Serial inputs are combinational and are valid only while s1/s0≠00; otherwise both are 0.
  - SHR: msb_in=fill.
  - SHL: lsb_in=fill.
  - ASR: msb_in=a_par[WIDTH-1].
  - ROR: msb_in=a_par[0].
  - ROL: lsb_in=a_par[WIDTH-1].
- i_par holds the latched cmd_data from acceptance until the next acceptance.
- cmd_abort sampled high in RUN:
  - At that edge, s1/s0 ← 00, state → DONE, abort flag set.
  - The register therefore performs no shift at that edge.
- cmd_abort is ignored outside RUN.
- cmd_valid in RUN/DONE is not accepted; the requester holds it until cmd_ready.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE; s1=s0=0; i_par=0; remaining=0.
  - done=aborted=err=0; cmd_ready=1 once rst deasserts.
- Reset mid-RUN: mode returns to hold immediately; the command is lost, with no done pulse.
- Command accepted at edge E with count N≥1: the register changes at edges E+1 … E+N.
  - done is high in the cycle after edge E+N, with the final value visible on a_par.
  - cmd_ready returns one cycle later.
- LOAD: register loads at edge E+1; done in the following cycle.
- Throughput: N+2 cycles per shift command; 3 cycles per LOAD; 2 cycles for count 0.
- Back-to-back: a new command can be accepted at the edge that leaves DONE's successor IDLE cycle (no combinational ready path).
- Abort sampled at edge A: shifts completed are those at edges E+1 … A-1.

## Configuration
- UNIVERSAL_SHIFT_CTRL_ROTATE_EN:
  - Defined: ROR/ROL are legal and behave as above.
  - Undefined: opcodes 100/101 are treated as illegal (err pulse, no register activity, state stays IDLE), and the a_par feedback is used only by ASR.

## Test plan
- Reset, then LOAD cmd_data=1011 → s1s0=11 for one cycle, a_par=1011, then done=1 with aborted=0.
- From 1011, SHR count=2 fill=1 → two edges with s1s0=01; a_par goes 1101 then 1110; done in the next cycle.
- From 1000, ASR count=3 → a_par 1100, 1110, 1111; then SHL count=0 → done after 2 cycles, a_par unchanged, s1s0 stays 00.
- From 1011, ROL count=4 with macro defined → a_par returns to 1011. Without the macro, the same command gives err=1, s1s0 stays 00 and a_par stays 1011.
- From 0001, SHL count=7 fill=0 with cmd_abort high in the 3rd RUN cycle → a_par=0100, done=1 with aborted=1.
- rst driven low mid-SHR → s1s0=00 immediately, no done; after release cmd_ready=1 and a new LOAD succeeds.
